// File: rtl/rib_arb_pkg.sv
// Shared definitions for the RIB bus arbiter: master indices, FSM states, default hold mask.
package rib_arb_pkg;

   localparam int M_CORE_DATA = 0;
   localparam int M_IFETCH    = 1;
   localparam int M_JTAG      = 2;
   localparam int M_UART_DBG  = 3;

   localparam logic [3:0] HOLD_MASK_DEF = 4'b1100;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rib_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr_i+1, wrapping.
module rr_pick #(
   parameter int NUM_M = 4,
   parameter int ID_W  = $clog2(NUM_M)
) (
   input  logic [NUM_M-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [NUM_M-1:0] gnt_o,
   output logic [ID_W-1:0]  id_o,
   output logic             any_o
);

   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      id_o  = '0;
      any_o = 1'b0;
      for (int k = 1; k <= NUM_M; k++) begin
         j = (int'(ptr_i) + k) % NUM_M;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            id_o     = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/rib_arbiter.sv
// RIB master arbiter: round-robin grant, locked bursts capped at MAX_LOCK, core hold flag.
// Optional wait-timeout abort is enabled by defining RIB_ARB_TIMEOUT_EN.
module rib_arbiter
   import rib_arb_pkg::*;
#(
   parameter int               NUM_M       = 4,
   parameter int               ID_W        = $clog2(NUM_M),
   parameter int               MAX_LOCK    = 8,
   parameter logic [NUM_M-1:0] HOLD_MASK   = NUM_M'(HOLD_MASK_DEF),
   parameter int               TIMEOUT_CYC = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_M-1:0] req_i,
   input  logic [NUM_M-1:0] lock_i,
   input  logic             ack_i,
   output logic [NUM_M-1:0] gnt_o,
   output logic [ID_W-1:0]  gnt_id_o,
   output logic             busy_o,
   output logic             hold_flag_o,
   output logic             timeout_err_o
);

   localparam int LCW = $clog2(MAX_LOCK + 1);

   arb_state_e       state, nxt_state;
   logic [NUM_M-1:0] pick_req, pick_gnt, nxt_gnt;
   logic [ID_W-1:0]  rr_ptr, nxt_ptr, nxt_id, pick_id;
   logic [LCW-1:0]   lock_cnt, nxt_lock;
   logic             nxt_busy, pick_any, tmo;

   // While busy, rr_ptr equals the owner, so masking it and searching from
   // ptr+1 drops the releasing owner to lowest priority.
   assign pick_req = (state == ARB_BUSY) ? (req_i & ~gnt_o) : req_i;

   rr_pick #(.NUM_M(NUM_M), .ID_W(ID_W)) u_pick (
      .req_i (pick_req),
      .ptr_i (rr_ptr),
      .gnt_o (pick_gnt),
      .id_o  (pick_id),
      .any_o (pick_any)
   );

`ifdef RIB_ARB_TIMEOUT_EN
   logic [15:0] wait_cnt;

   assign tmo = (state == ARB_BUSY) && !ack_i && (wait_cnt == 16'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt      <= '0;
         timeout_err_o <= 1'b0;
      end else begin
         wait_cnt      <= (state != ARB_BUSY || ack_i || tmo) ? '0 : wait_cnt + 16'd1;
         timeout_err_o <= tmo;
      end
   end
`else
   assign tmo           = 1'b0;
   assign timeout_err_o = 1'b0;
`endif

   always_comb begin
      nxt_state = state;
      nxt_gnt   = gnt_o;
      nxt_id    = gnt_id_o;
      nxt_busy  = busy_o;
      nxt_ptr   = rr_ptr;
      nxt_lock  = lock_cnt;
      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               nxt_state = ARB_BUSY;
               nxt_gnt   = pick_gnt;
               nxt_id    = pick_id;
               nxt_busy  = 1'b1;
               nxt_ptr   = pick_id;
               nxt_lock  = '0;
            end
         end
         ARB_BUSY: begin
            if (ack_i || tmo) begin
               if (ack_i && lock_i[gnt_id_o] && req_i[gnt_id_o] &&
                   lock_cnt < LCW'(MAX_LOCK - 1)) begin
                  nxt_lock = lock_cnt + 1'b1;
               end else if (pick_any) begin
                  nxt_gnt  = pick_gnt;
                  nxt_id   = pick_id;
                  nxt_ptr  = pick_id;
                  nxt_lock = '0;
               end else if (req_i[gnt_id_o]) begin
                  nxt_lock = '0;
               end else begin
                  nxt_state = ARB_IDLE;
                  nxt_gnt   = '0;
                  nxt_busy  = 1'b0;
                  nxt_lock  = '0;
               end
            end else if (!req_i[gnt_id_o]) begin
               nxt_state = ARB_IDLE;
               nxt_gnt   = '0;
               nxt_busy  = 1'b0;
               nxt_lock  = '0;
            end
         end
         default: nxt_state = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ARB_IDLE;
         gnt_o       <= '0;
         gnt_id_o    <= '0;
         busy_o      <= 1'b0;
         hold_flag_o <= 1'b0;
         rr_ptr      <= ID_W'(NUM_M - 1);
         lock_cnt    <= '0;
      end else begin
         state       <= nxt_state;
         gnt_o       <= nxt_gnt;
         gnt_id_o    <= nxt_id;
         busy_o      <= nxt_busy;
         hold_flag_o <= |(nxt_gnt & HOLD_MASK);
         rr_ptr      <= nxt_ptr;
         lock_cnt    <= nxt_lock;
      end
   end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
Round-robin bus arbiter that decides which RIB master (core data port, instruction fetch, JTAG debug, UART download) owns the shared slave fabric. It sequences each transaction from grant to slave acknowledge, supports locked multi-beat ownership with a fairness cap, and drives the pipeline hold flag to the core. It sits between the master request lines and the RIB address/data muxes, which are steered by gnt_id_o.

Parameters:
NUM_M, 4, number of masters (2..8)
ID_W, $clog2(NUM_M), width of grant index
MAX_LOCK, 8, maximum consecutive acknowledged beats one master may hold under lock
HOLD_MASK, 4'b1100, masters whose ownership asserts hold_flag_o (bit i = master i)
TIMEOUT_CYC, 256, cycles without ack before abort (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_i  in  NUM_M  per-master request, level
lock_i  in  NUM_M  per-master lock: keep ownership after the current ack
ack_i  in  1  slave completed the current access
gnt_o  out  NUM_M  one-hot grant, registered
gnt_id_o  out  ID_W  binary index of the granted master, registered
busy_o  out  1  a grant is active
hold_flag_o  out  1  registered; high while a HOLD_MASK master is granted
timeout_err_o  out  1  one-cycle abort pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Clock clk; reset rst is synchronous and active-high. Reset: gnt_o=0, gnt_id_o=0, busy_o=0, hold_flag_o=0, timeout_err_o=0, rr_ptr=NUM_M-1, lock_cnt=0, state IDLE.
- States: IDLE, BUSY.
- IDLE: when any req_i is set, pick the first set bit searching upward from rr_ptr+1 with modulo-NUM_M wrap-around. gnt_o, gnt_id_o and busy_o assert on the next edge, giving 1-cycle latency from req to grant. rr_ptr <= winner. Go to BUSY with lock_cnt=0.
- BUSY, ack_i=1:
  - If lock_i[gnt_id] && req_i[gnt_id] && lock_cnt<MAX_LOCK-1, keep the grant and lock_cnt++.
  - Otherwise release and re-arbitrate in the same cycle over req_i, masking the current owner. The new grant appears on the next edge with no idle bubble. If no other master requests, a requesting current owner is re-granted. If nothing requests, go to IDLE.
  - A forced release at MAX_LOCK always sends the owner to lowest priority.
- BUSY, ack_i=0, req_i[gnt_id]=0: abort. Grant drops on the next edge, go to IDLE, rr_ptr keeps the aborting owner.
- BUSY, ack_i=0, req_i[gnt_id]=1: hold the grant unchanged. Requests from other masters are ignored.
- ack_i in IDLE is ignored.
- req_i and lock_i changes from non-owners never affect a current grant.
- hold_flag_o = registered |(gnt_next & HOLD_MASK), so it is aligned with gnt_o.
- gnt_o is always one-hot or zero. gnt_id_o holds its last value when busy_o=0.

Optional Feature:
RIB_ARB_TIMEOUT_EN
- Defined: an 8..16-bit wait counter resets on every grant and every ack and increments each BUSY cycle with ack_i=0. When it reaches TIMEOUT_CYC-1:
  - timeout_err_o pulses for 1 cycle;
  - the grant is released;
  - re-arbitration follows the same rules as a forced release.
- Undefined: no counter; timeout_err_o tied 0; BUSY waits indefinitely.

Decomposition:
- Shared package rib_arb_pkg: master index constants (M_CORE_DATA=0, M_IFETCH=1, M_JTAG=2, M_UART_DBG=3), state encoding, default HOLD_MASK.
- One sub-module, rr_pick: combinational round-robin priority encoder (inputs req mask and start pointer; outputs one-hot and index). Used once.

Test Plan:
- Reset, then req_i=4'b0001 at cycle 0 → gnt_o=4'b0001, gnt_id_o=0, busy_o=1 at cycle 1; hold_flag_o=0.
- req_i=4'b1111 held, ack_i=1 every cycle, lock_i=0 → grants rotate 0,1,2,3,0 on consecutive cycles; hold_flag_o high exactly on the grant-2 and grant-3 cycles.
- Master 2 with lock_i[2]=1, req_i=4'b0110, ack every cycle → master 2 owns 8 acked beats, master 1 is granted on the 9th; master 2 is not re-granted before master 1.
- Owner 3 drops req_i[3] without ack while req_i[0]=1 → grant drops next cycle, IDLE, then master 0 is granted the following cycle.
- rst=1 asserted mid-BUSY with lock active → all outputs 0 on the next edge; first post-reset grant goes to the lowest-index requester.
- With RIB_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: grant master 1 with no ack → timeout_err_o pulses on the 16th BUSY cycle and the grant releases; without the macro the grant persists for 100+ cycles.
